// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter:
// FSM state encoding, grant owner identifiers and counter widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Streak counter holds 0..15; wait counter holds 0..255.
  localparam int STREAK_W = 4;
  localparam int WAIT_W   = 8;

  // Which requester owns the bus in a grant state.
  function automatic grant_t grant_of(input arb_state_t s);
    return (s == GNT_D) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Wait-state watchdog for mem_arbiter. Only built when MEM_ARB_TIMEOUT_EN
// is defined; without the macro this file contributes no logic.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic m_ack,
  output logic expired
);

  // cnt holds the number of GNT cycles already spent without m_ack, so the
  // TIMEOUT-th waiting cycle is the one where cnt equals TIMEOUT-1.
  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] cnt;

  // Clear outside grant states, count every grant cycle that sees no m_ack.
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      cnt <= '0;
    end else if (!m_ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = active && (cnt == LAST);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (i_*) and load/store (d_*).
// Data wins ties unless it has already taken MAX_STREAK grants in a row while
// fetch was waiting. All outputs are registered.
//
// Handshake: a requester raises x_req with stable fields and holds them until
// the one-cycle x_ack pulse; it may drop or change the request in the cycle
// after x_ack. m_req is held with stable m_* fields until m_ack, and m_rdata
// is sampled in the m_ack cycle.
//
// Optional: define MEM_ARB_TIMEOUT_EN to abort a grant after TIMEOUT wait
// cycles with bus_err set; otherwise grants wait forever and bus_err is 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_rdata,
  output logic            bus_err
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  // Marker block: only present in the hierarchy for an illegal configuration.
  if (MAX_STREAK < 1 || MAX_STREAK > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_config
  end

  arb_state_t            state, state_nxt;
  logic [STREAK_W-1:0]   streak, streak_nxt;
  logic                  m_req_nxt, m_we_nxt;
  logic [AW-1:0]         m_addr_nxt;
  logic [DW-1:0]         m_wdata_nxt;
  logic [DW/8-1:0]       m_be_nxt;
  logic                  i_ack_nxt, d_ack_nxt, bus_err_nxt;
  logic [DW-1:0]         i_rdata_nxt, d_rdata_nxt;
  logic                  wait_expired;
  logic                  fault;

`ifdef MEM_ARB_TIMEOUT_EN
  logic in_gnt;
  assign in_gnt = (state == GNT_I) || (state == GNT_D);

  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (in_gnt),
    .m_ack   (m_ack),
    .expired (wait_expired)
  );
`else
  assign wait_expired = 1'b0;
`endif

  // A timeout only counts as a fault when memory did not answer that cycle.
  assign fault = wait_expired && !m_ack;

  // Next-state, grant selection and registered-output values.
  always_comb begin
    state_nxt   = state;
    streak_nxt  = streak;
    m_req_nxt   = m_req;
    m_we_nxt    = m_we;
    m_addr_nxt  = m_addr;
    m_wdata_nxt = m_wdata;
    m_be_nxt    = m_be;
    i_ack_nxt   = 1'b0;
    d_ack_nxt   = 1'b0;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    bus_err_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && !(i_req && streak == STREAK_MAX)) begin
          state_nxt   = GNT_D;
          streak_nxt  = !i_req ? '0 : ((streak == STREAK_MAX) ? streak : streak + 1'b1);
          m_req_nxt   = 1'b1;
          m_we_nxt    = d_we;
          m_addr_nxt  = d_addr;
          m_wdata_nxt = d_wdata;
          m_be_nxt    = d_be;
        end else if (i_req) begin
          state_nxt   = GNT_I;
          streak_nxt  = '0;
          m_req_nxt   = 1'b1;
          m_we_nxt    = 1'b0;
          m_addr_nxt  = i_addr;
          m_wdata_nxt = '0;
          m_be_nxt    = '1;
        end
      end
      GNT_I, GNT_D: begin
        if (m_ack || fault) begin
          state_nxt   = RESP;
          m_req_nxt   = 1'b0;
          bus_err_nxt = fault;
          if (grant_of(state) == GRANT_D) begin
            d_ack_nxt   = 1'b1;
            d_rdata_nxt = fault ? '0 : m_rdata;
          end else begin
            i_ack_nxt   = 1'b1;
            i_rdata_nxt = fault ? '0 : m_rdata;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      streak  <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      streak  <= streak_nxt;
      m_req   <= m_req_nxt;
      m_we    <= m_we_nxt;
      m_addr  <= m_addr_nxt;
      m_wdata <= m_wdata_nxt;
      m_be    <= m_be_nxt;
      i_ack   <= i_ack_nxt;
      d_ack   <= d_ack_nxt;
      i_rdata <= i_rdata_nxt;
      d_rdata <= d_rdata_nxt;
      bus_err <= bus_err_nxt;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single memory port between the instruction-fetch stage and the load/store (data) stage of the two-stage core.
- Sits between the core's two bus masters and the memory/peripheral bus.
- Data accesses have priority; a bounded-streak rule guarantees forward progress for fetch.
- Multi-cycle memory responses are supported via a req/ack handshake.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; DW must be a multiple of 8.
- MAX_STREAK, 4, maximum consecutive data grants while fetch is waiting; range 1..15.
- TIMEOUT, 255, wait-state cycles before a bus error; used only with the optional feature; range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  AW  fetch address.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_rdata  out  DW  fetch data; valid when i_ack=1.
- d_req  in  1  data request; held with its fields stable until d_ack.
- d_we  in  1  data write enable.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_be  in  DW/8  byte enables.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DW  load data; valid when d_ack=1.
- m_req  out  1  memory request; held until m_ack.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_be  out  DW/8  memory byte enables.
- m_ack  in  1  memory completion; m_rdata is valid in the same cycle.
- m_rdata  in  DW  memory read data.
- bus_err  out  1  error flag accompanying i_ack/d_ack.

Behaviour:
- Reset values (rst_n low, sampled at posedge): state=IDLE, all outputs 0, streak=0.
  - Reset mid-transaction abandons the transaction. No ack is issued; memory shares the same reset.
- States: IDLE, GNT_I, GNT_D, RESP. All outputs are registered.
- IDLE:
  - If d_req && !(i_req && streak==MAX_STREAK): go to GNT_D. streak increments when i_req is also high, saturating at MAX_STREAK; otherwise streak=0.
  - Else if i_req: go to GNT_I, streak=0.
  - Else stay in IDLE.
  - On entering a GNT state: m_req=1 and m_addr/m_we/m_wdata/m_be are latched from the winner.
  - Fetch grants drive m_we=0 and m_be=all ones.
- GNT_x:
  - m_req and all m_* fields stay stable until m_ack.
  - On m_ack: latch m_rdata into x_rdata, set x_ack=1, m_req=0, go to RESP.
- RESP: ack is high for exactly this cycle. Next state is IDLE and the ack clears.
- Requester rule: a requester may drop its req, or present a new request, in the cycle after ack. IDLE never re-grants a stale request.
- Latency:
  - req sampled in IDLE at cycle N gives m_req=1 at N+1.
  - A zero-wait m_ack at N+1 gives ack at N+2 and IDLE at N+3.
  - Throughput is 1 transfer per 3 cycles plus wait states.
- m_ack outside a GNT state is ignored.
- Simultaneous i_req and d_req: data wins unless streak==MAX_STREAK.
- i_rdata/d_rdata hold their last value between acks. The other requester's ack stays 0.
- bus_err is 0 unless the optional feature fires.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entering GNT_x and increments each GNT cycle without m_ack.
  - When it reaches TIMEOUT: m_req=0, x_ack=1, bus_err=1, x_rdata=0, go to RESP.
  - bus_err is high only in that RESP cycle.
  - m_ack arriving in the same cycle as the timeout wins, and the access completes normally.
- Undefined: GNT waits indefinitely; bus_err is tied to 0 and no counter logic exists.

Decomposition:
- mem_arb_pkg holds:
  - state encoding enum (IDLE=0, GNT_I=1, GNT_D=2, RESP=3);
  - GRANT_I/GRANT_D identifiers;
  - streak and wait-counter widths.
- A single sub-module, mem_arb_wdog (wait counter plus timeout compare), is instantiated only under MEM_ARB_TIMEOUT_EN. The rest is one module.

Test Plan:
- Single fetch, i_addr=0x100, m_ack with zero wait, m_rdata=0xDEADBEEF -> m_req high at N+1 only; i_ack at N+2 with i_rdata=0xDEADBEEF; d_ack stays 0.
- Data write, d_addr=0x2000, d_wdata=0x12345678, d_be=4'b0011, 3 wait states -> m_we=1 and m_be=0011 stable for 4 cycles; d_ack 1 cycle after m_ack.
- i_req and d_req held continuously, MAX_STREAK=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; no fetch waits more than 4 data transfers.
- Reset asserted while in GNT_D with m_ack low -> next cycle m_req=0, d_ack=0, state IDLE; a request after reset completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, m_ack never asserted -> m_req drops after 8 GNT cycles; d_ack=1, bus_err=1, d_rdata=0 for one cycle.
- With MEM_ARB_TIMEOUT_EN, m_ack on the timeout cycle -> normal completion with bus_err=0.
